// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - rysyCore data-memory load/store stage on a valid/ready bus.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int REG_LEN     = 32,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_load,
  input  logic               req_store,
  input  logic [2:0]         funct3,
  input  logic [REG_LEN-1:0] addr,
  input  logic [REG_LEN-1:0] wdata,
  output logic               bus_valid,
  output logic               bus_we,
  output logic [REG_LEN-1:0] bus_addr,
  output logic [3:0]         bus_be,
  output logic [REG_LEN-1:0] bus_wdata,
  input  logic               bus_ready,
  input  logic [REG_LEN-1:0] bus_rdata,
  output logic [REG_LEN-1:0] rd_mem,
  output logic               busy,
  output logic               done,
  output logic               bus_err,
  output logic               misalign
);

  localparam int CNT_W = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t             r_state, w_next;
  logic               r_we, r_err;
  logic [2:0]         r_f3;
  logic [REG_LEN-1:0] r_addr, r_wdata;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_req, w_valid, w_timeout, w_mis;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [3:0]         w_be;
  logic [REG_LEN-1:0] w_lane, w_load;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;

  assign w_req     = req_load | req_store;
  assign w_valid   = (r_state == S_REQ);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (BUS_TIMEOUT != 0) && !bus_ready && (w_cnt_inc == CNT_W'(BUS_TIMEOUT));

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_mis;
  // funct3[1:0]: 00 byte, 01 half, anything else is a word access
  assign w_mis    = ((funct3[1:0] == 2'b01) && addr[0]) || (funct3[1] && (addr[1:0] != 2'b00));
  assign misalign = (r_state == S_DONE) && r_mis;
`else
  assign w_mis    = 1'b0;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = w_mis ? S_DONE : S_REQ;
      S_REQ:   if (bus_ready || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_be   = 4'b1111;
    w_lane = r_wdata;
    if (r_we) begin
      case (r_f3[1:0])
        2'b00: begin
          w_be   = 4'b0001 << r_addr[1:0];
          w_lane = {4{r_wdata[7:0]}};
        end
        2'b01: begin
          w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
          w_lane = {2{r_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = bus_rdata[7:0];
      2'b01:   w_byte = bus_rdata[15:8];
      2'b10:   w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    w_half = r_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_f3[1:0])
      2'b00:   w_load = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_f3[2] & w_half[15]}}, w_half};
      default: w_load = bus_rdata;
    endcase
  end

  assign bus_valid = w_valid;
  assign bus_we    = w_valid & r_we;
  assign bus_addr  = w_valid ? {r_addr[REG_LEN-1:2], 2'b00} : '0;
  assign bus_be    = w_valid ? w_be : 4'b0000;
  assign bus_wdata = (w_valid & r_we) ? w_lane : '0;
  assign busy      = ((r_state == S_IDLE) & w_req) | w_valid;
  assign done      = (r_state == S_DONE);
  assign bus_err   = (r_state == S_DONE) & r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      rd_mem  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_mis   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_req) begin
          r_we    <= req_store;
          r_f3    <= funct3;
          r_addr  <= addr;
          r_wdata <= wdata;
          r_cnt   <= '0;
          r_err   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          r_mis   <= w_mis;
`endif
        end
        S_REQ: begin
          if (bus_ready) begin
            if (!r_we) rd_mem <= w_load;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_load, req_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, rd_mem;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic        busy, done, bus_err, misalign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.REG_LEN(32), .BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_load(req_load), .req_store(req_store), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .rd_mem(rd_mem), .busy(busy), .done(done),
    .bus_err(bus_err), .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // zero-wait-state load: request cycle, one REQ cycle, then DONE
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [31:0] exp_rd);
    @(negedge clk);
    req_load = 1'b1; funct3 = f3; addr = a;
    #1 chk({tag, "_busy_req"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    req_load = 1'b0;
    chk({tag, "_valid"}, {31'd0, bus_valid}, 32'd1);
    chk({tag, "_addr"}, bus_addr, exp_addr);
    chk({tag, "_be"}, {28'd0, bus_be}, 32'hF);
    chk({tag, "_we"}, {31'd0, bus_we}, 32'd0);
    chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
    bus_ready = 1'b1; bus_rdata = rdata;
    @(negedge clk);
    bus_ready = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rd_mem"}, rd_mem, exp_rd);
    chk({tag, "_err"}, {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_load = 1'b0; req_store = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    #12;
    chk("rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);
    chk("rst_rd_mem", rd_mem, 32'd0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_load("lb", 3'b000, 32'h103, 32'h80FF_1234, 32'h100, 32'hFFFF_FF80);
    run_load("lhu", 3'b101, 32'h102, 32'h8001_0000, 32'h100, 32'h0000_8001);
    run_load("lh", 3'b001, 32'h102, 32'h8001_0000, 32'h100, 32'hFFFF_8001);
    run_load("lbu", 3'b100, 32'h101, 32'h0000_9C00, 32'h100, 32'h0000_009C);

    // SB with three wait states
    @(negedge clk);
    req_store = 1'b1; funct3 = 3'b000; addr = 32'h201; wdata = 32'h0000_00A5;
    @(negedge clk);
    req_store = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sb_valid", {31'd0, bus_valid}, 32'd1);
      chk("sb_we", {31'd0, bus_we}, 32'd1);
      chk("sb_be", {28'd0, bus_be}, 32'h2);
      chk("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
      chk("sb_addr", bus_addr, 32'h200);
      chk("sb_busy", {31'd0, busy}, 32'd1);
      if (i == 3) bus_ready = 1'b1;
      @(negedge clk);
    end
    bus_ready = 1'b0;
    chk("sb_done", {31'd0, done}, 32'd1);
    chk("sb_rd_mem", rd_mem, 32'h0000_009C);

    // SH upper half
    @(negedge clk);
    req_store = 1'b1; funct3 = 3'b001; addr = 32'h202; wdata = 32'h1234_BEEF;
    @(negedge clk);
    req_store = 1'b0;
    chk("sh_be", {28'd0, bus_be}, 32'hC);
    chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    chk("sh_done", {31'd0, done}, 32'd1);

    // store wins over a simultaneous load
    @(negedge clk);
    req_store = 1'b1; req_load = 1'b1; funct3 = 3'b010; addr = 32'h500; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req_store = 1'b0; req_load = 1'b0;
    chk("sw_we", {31'd0, bus_we}, 32'd1);
    chk("sw_be", {28'd0, bus_be}, 32'hF);
    chk("sw_wdata", bus_wdata, 32'hDEAD_BEEF);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    chk("sw_done", {31'd0, done}, 32'd1);

    // timeout: four REQ cycles then abort
    @(negedge clk);
    req_load = 1'b1; funct3 = 3'b010; addr = 32'h300; bus_rdata = 32'h5555_5555;
    @(negedge clk);
    req_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_valid", {31'd0, bus_valid}, 32'd1);
      chk("to_done_early", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    chk("to_valid_drop", {31'd0, bus_valid}, 32'd0);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_err", {31'd0, bus_err}, 32'd1);
    chk("to_rd_mem", rd_mem, 32'h0000_009C);
    @(negedge clk);
    chk("to_err_clr", {31'd0, bus_err}, 32'd0);

    // asynchronous reset in the middle of REQ
    @(negedge clk);
    req_load = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    req_load = 1'b0;
    chk("ar_valid_pre", {31'd0, bus_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, bus_valid}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_rd_mem", rd_mem, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ar_done", {31'd0, done}, 32'd0);
    run_load("lw_post", 3'b010, 32'h600, 32'hCAFE_F00D, 32'h600, 32'hCAFE_F00D);

    // misaligned word
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    req_load = 1'b1; funct3 = 3'b010; addr = 32'h102;
    @(negedge clk);
    req_load = 1'b0;
    chk("mis_valid", {31'd0, bus_valid}, 32'd0);
    chk("mis_done", {31'd0, done}, 32'd1);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_rd_mem", rd_mem, 32'hCAFE_F00D);
    @(negedge clk);
    chk("mis_flag_clr", {31'd0, misalign}, 32'd0);
`else
    run_load("lw_mis", 3'b010, 32'h102, 32'h1234_5678, 32'h100, 32'h1234_5678);
    chk("mis_tied", {31'd0, misalign}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
